nms_seq: RTL

- Non-maximum-suppression read sequencer; the consumer side of the NMS score-memory address path.
- Per request it walks adjacency numbers 0 (centre) then 1..8 (neighbours) into the NMS address calculator, and collects the returned scores from the score memory.
- Decides whether the centre pixel is a strict local maximum and reports the keypoint address and score to the downstream keypoint writer.
- Sits between the FAST score stage (which raises start with a reference address) and the score memory read port.

---
 rtl/nms_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/nms_seq.sv
// Non-maximum-suppression read sequencer: walks adjacency 0..8 into the address
// calculator, collects returned scores and reports whether the centre is a strict maximum.
module nms_seq #(
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned CENTER_OFS = 182
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [14:0]        refAddr,
  input  logic [SCORE_W-1:0] scoreData,
  output logic [3:0]         adjNumber,
  output logic               busy,
  output logic               done,
  output logic               isMax,
  output logic [14:0]        keyAddr,
  output logic [SCORE_W-1:0] keyScore
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(RD_LAT - 1);

  state_t             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [14:0]        ref_q, ref_d;
  logic [RD_LAT-1:0]  tag_vld_q, tag_vld_d;
  logic [3:0]         tag_k_q [RD_LAT];
  logic [3:0]         tag_k_d [RD_LAT];
  logic [SCORE_W-1:0] centre_q, centre_d;
  logic               acc_q, acc_d;
  logic               is_max_q, is_max_d;
  logic [14:0]        key_addr_q, key_addr_d;
  logic [SCORE_W-1:0] key_score_q, key_score_d;

  // k counts adjacency numbers in ISSUE and is reused as the drain counter.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    ref_d     = ref_q;
    adjNumber = 4'hF;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          k_d     = '0;
          ref_d   = refAddr;
        end
      end
      S_ISSUE: begin
        busy      = 1'b1;
        adjNumber = k_q;
        if (k_q == 4'd8) begin
          state_d = S_DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (k_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = S_ISSUE;
          k_d     = '0;
          ref_d   = refAddr;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tag_vld_d[0] = (state_q == S_ISSUE);
    tag_k_d[0]   = k_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_k_d[i]   = tag_k_q[i-1];
    end
  end

  // The final neighbour sample lands in the same cycle as the DRAIN->DONE
  // transition, so results are taken from the _d values.
  always_comb begin
    centre_d    = centre_q;
    acc_d       = acc_q;
    is_max_d    = is_max_q;
    key_addr_d  = key_addr_q;
    key_score_d = key_score_q;
    if (tag_vld_q[RD_LAT-1]) begin
      if (tag_k_q[RD_LAT-1] == 4'd0) begin
        centre_d = scoreData;
        acc_d    = (scoreData != '0);
      end else if (scoreData >= centre_q) begin
        acc_d = 1'b0;
      end
    end
    if (state_q == S_DRAIN && state_d == S_DONE) begin
      is_max_d    = acc_d;
      key_score_d = centre_d;
      key_addr_d  = ref_q - 15'(CENTER_OFS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      ref_q       <= '0;
      tag_vld_q   <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_k_q[i] <= '0;
      centre_q    <= '0;
      acc_q       <= 1'b0;
      is_max_q    <= 1'b0;
      key_addr_q  <= '0;
      key_score_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ref_q       <= ref_d;
      tag_vld_q   <= tag_vld_d;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_k_q[i] <= tag_k_d[i];
      centre_q    <= centre_d;
      acc_q       <= acc_d;
      is_max_q    <= is_max_d;
      key_addr_q  <= key_addr_d;
      key_score_q <= key_score_d;
    end
  end

  assign isMax    = is_max_q;
  assign keyAddr  = key_addr_q;
  assign keyScore = key_score_q;

endmodule
